// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner for the MM:SS timer digits.
// Optional flashing is compiled in when SEG_BLINK_EN is defined.
module seven_seg_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic       clk100MHz,
    input  logic       reset,
    input  logic [3:0] tenmin,
    input  logic [3:0] onemin,
    input  logic [3:0] tensec,
    input  logic [3:0] onesec,
    input  logic       lz_blank,
    input  logic       colon_en,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LP_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LP_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_idx;
    logic [3:0][3:0] r_snap;
    logic            r_first;

    logic [3:0][3:0] w_live;
    logic [3:0][3:0] w_snap_cur;
    logic [3:0]      w_digit;
    logic            w_wrap;
    logic            w_frame_end;
    logic            w_blank_win;
    logic [6:0]      w_seg_dec;
    logic [3:0]      w_an_nxt;
    logic [6:0]      w_seg_nxt;
    logic            w_dp_nxt;

    assign w_live      = {tenmin, onemin, tensec, onesec};
    // On the first clock after reset the fresh capture is shown immediately.
    assign w_snap_cur  = r_first ? w_live : r_snap;
    assign w_digit     = w_snap_cur[r_idx];
    assign w_wrap      = (r_cnt == LP_LAST);
    assign w_frame_end = w_wrap && (r_idx == 2'd3);
    assign w_blank_win = (r_cnt < LP_BLANK);

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_snap  <= '0;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            r_cnt   <= w_wrap ? '0 : r_cnt + CW'(1);
            if (w_wrap)
                r_idx <= r_idx + 2'd1;
            if (r_first || w_frame_end)
                r_snap <= w_live;
        end
    end

    always_comb begin
        w_seg_dec = 7'b0111111;
        case (w_digit)
            4'd0: w_seg_dec = 7'b1000000;
            4'd1: w_seg_dec = 7'b1111001;
            4'd2: w_seg_dec = 7'b0100100;
            4'd3: w_seg_dec = 7'b0110000;
            4'd4: w_seg_dec = 7'b0011001;
            4'd5: w_seg_dec = 7'b0010010;
            4'd6: w_seg_dec = 7'b0000010;
            4'd7: w_seg_dec = 7'b1111000;
            4'd8: w_seg_dec = 7'b0000000;
            4'd9: w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b0111111;
        endcase
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] LP_BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_bcnt;
    logic          r_phase;

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == LP_BLINK_LAST) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + BW'(1);
        end
    end
`else
    logic w_blink_unused;
    assign w_blink_unused = blink;
`endif

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 7'b1111111;
        w_dp_nxt  = 1'b1;
        if (!w_blank_win) begin
            w_seg_nxt = w_seg_dec;
            if (!(lz_blank && (r_idx == 2'd3) && (w_digit == 4'd0)))
                w_an_nxt = ~(4'b0001 << r_idx);
            w_dp_nxt = !(colon_en && (r_idx == 2'd2));
        end
`ifdef SEG_BLINK_EN
        if (blink && r_phase) begin
            w_an_nxt = 4'b1111;
            w_dp_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= w_an_nxt;
            seg <= w_seg_nxt;
            dp  <= w_dp_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with small refresh/blank/blink dividers.
// A frame-level reference model derives the expected display from elapsed clocks.
module tb_seven_seg_scan;

    localparam int R  = 4;
    localparam int B  = 1;
    localparam int BD = 8;

    logic       clk;
    logic       reset;
    logic [3:0] tenmin, onemin, tensec, onesec;
    logic       lz_blank, colon_en, blink;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp;
    int n_bad;

    seven_seg_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .BLINK_DIV(BD)) dut (
        .clk100MHz(clk), .reset(reset),
        .tenmin(tenmin), .onemin(onemin), .tensec(tensec), .onesec(onesec),
        .lz_blank(lz_blank), .colon_en(colon_en), .blink(blink),
        .an(an), .seg(seg), .dp(dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] dec(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Reference model: m_t is the number of clocks since reset release.
    int         m_t;
    int         m_snap[4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    always @(posedge clk or posedge reset) begin : model_blk
        int idx;
        int c;
        if (reset) begin
            m_t     = 0;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
        end else begin
            idx = (m_t / R) % 4;
            c   = m_t % R;
            if (m_t == 0) begin
                m_snap[0] = int'(onesec); m_snap[1] = int'(tensec);
                m_snap[2] = int'(onemin); m_snap[3] = int'(tenmin);
            end
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
            if (c >= B) begin
                exp_seg = dec(m_snap[idx]);
                if (!(lz_blank && idx == 3 && m_snap[3] == 0))
                    exp_an[idx] = 1'b0;
                exp_dp = !(colon_en && idx == 2);
            end
`ifdef SEG_BLINK_EN
            if (blink && ((m_t / BD) % 2 == 1)) begin
                exp_an = 4'b1111;
                exp_dp = 1'b1;
            end
`endif
            if (m_t % (4 * R) == 4 * R - 1) begin
                m_snap[0] = int'(onesec); m_snap[1] = int'(tensec);
                m_snap[2] = int'(onemin); m_snap[3] = int'(tenmin);
            end
            m_t++;
        end
    end

    task automatic set_digits(input int tm, input int om, input int ts, input int os);
        tenmin = 4'(tm); onemin = 4'(om); tensec = 4'(ts); onesec = 4'(os);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL reset_an got %b want 1111", an); end
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL reset_seg got %b want 1111111", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got %b want 1", dp); end
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL reset_hold_an got %b want 1111", an); end
        end
        reset = 1'b0;
    endtask

    task automatic test_scan_order;
        logic [3:0] an_tab[4];
        logic [6:0] seg_tab[4];
        logic [3:0] w_an;
        logic [6:0] w_seg;
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        set_digits(1, 2, 3, 4);
        lz_blank = 0; colon_en = 0; blink = 0;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k % R < B) begin w_an = 4'b1111; w_seg = 7'b1111111; end
            else begin w_an = an_tab[(k / R) % 4]; w_seg = seg_tab[(k / R) % 4]; end
            n_cmp++; if (an !== w_an) begin n_bad++; $display("FAIL scan_an k=%0d got %b want %b", k, an, w_an); end
            n_cmp++; if (seg !== w_seg) begin n_bad++; $display("FAIL scan_seg k=%0d got %b want %b", k, seg, w_seg); end
        end
    endtask

    task automatic test_snapshot;
        set_digits(1, 2, 3, 4);
        do_reset();
        repeat (9) @(negedge clk);
        onesec = 4'd7;
        for (int k = 9; k < 25; k++) begin
            @(negedge clk);
            n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL snap_an k=%0d got %b want %b", k, an, exp_an); end
            n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL snap_seg k=%0d got %b want %b", k, seg, exp_seg); end
            if (k >= 4 * R + B && k < 5 * R) begin
                n_cmp++; if (seg !== 7'b1111000) begin n_bad++; $display("FAIL snap_new_digit k=%0d got %b want 1111000", k, seg); end
            end
        end
    endtask

    task automatic test_lz_invalid;
        set_digits(0, 5, 12, 9);
        lz_blank = 1;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            if (k == 16) lz_blank = 0;
            @(negedge clk);
            if ((k / R) % 4 == 3) begin
                if (k < 16) begin
                    n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL lz_blank_an k=%0d got %b want 1111", k, an); end
                end else if (k % R >= B) begin
                    n_cmp++; if (an !== 4'b0111) begin n_bad++; $display("FAIL lz_off_an k=%0d got %b want 0111", k, an); end
                    n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL lz_off_seg k=%0d got %b want 1000000", k, seg); end
                end
            end
            if ((k / R) % 4 == 1 && k % R >= B) begin
                n_cmp++; if (seg !== 7'b0111111) begin n_bad++; $display("FAIL dash_seg k=%0d got %b want 0111111", k, seg); end
            end
        end
        lz_blank = 0;
    endtask

    task automatic test_colon;
        logic w_dp;
        set_digits($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
        colon_en = 1;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            w_dp = !((k / R) % 4 == 2 && k % R >= B);
            n_cmp++; if (dp !== w_dp) begin n_bad++; $display("FAIL colon_dp k=%0d got %b want %b", k, dp, w_dp); end
        end
        colon_en = 0;
    endtask

    task automatic test_reset_mid;
        set_digits(1, 2, 3, 4);
        colon_en = 1;
        do_reset();
        repeat (10) @(negedge clk);
        n_cmp++; if (an !== 4'b1011) begin n_bad++; $display("FAIL mid_pre_an got %b want 1011", an); end
        reset = 1'b1;
        #1;
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL mid_rst_an got %b want 1111", an); end
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL mid_rst_seg got %b want 1111111", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL mid_rst_dp got %b want 1", dp); end
        onesec = 4'd6;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= B && k < R) begin
                n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL mid_first_an k=%0d got %b want 1110", k, an); end
                n_cmp++; if (seg !== 7'b0000010) begin n_bad++; $display("FAIL mid_first_seg k=%0d got %b want 0000010", k, seg); end
            end
            n_cmp++; if (dp !== exp_dp) begin n_bad++; $display("FAIL mid_dp k=%0d got %b want %b", k, dp, exp_dp); end
        end
        colon_en = 0;
    endtask

    task automatic test_random;
        set_digits($urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: tenmin = 4'($urandom_range(0, 2));
                    1: onemin = 4'($urandom_range(0, 15));
                    2: tensec = 4'($urandom_range(0, 15));
                    default: onesec = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) colon_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) blink = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL rand_an k=%0d got %b want %b", k, an, exp_an); end
            n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL rand_seg k=%0d got %b want %b", k, seg, exp_seg); end
            n_cmp++; if (dp !== exp_dp) begin n_bad++; $display("FAIL rand_dp k=%0d got %b want %b", k, dp, exp_dp); end
        end
        lz_blank = 0; colon_en = 0; blink = 0;
    endtask

    task automatic test_blink;
        set_digits(1, 2, 3, 4);
        colon_en = 1;
        blink = 1;
        do_reset();
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
`ifdef SEG_BLINK_EN
            if ((k / BD) % 2 == 1) begin
                n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL blink_off_an k=%0d got %b want 1111", k, an); end
                n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL blink_off_dp k=%0d got %b want 1", k, dp); end
            end
`endif
            n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL blink_an k=%0d got %b want %b", k, an, exp_an); end
            if (k == 24) blink = 0;
        end
        blink = 0;
        colon_en = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        set_digits(0, 0, 0, 0);
        lz_blank = 0; colon_en = 0; blink = 0;
        test_reset();
        test_scan_order();
        test_snapshot();
        test_lz_invalid();
        test_colon();
        test_reset_mid();
        test_blink();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
